// File: rtl/ym_pkg.sv
// ym_pkg
// Shared types and default timing for the YMF262 write scheduler.
//   ym_state_t  : scheduler FSM states (IDLE, SETUP, STROBE, HOLD, RECOVER)
//   ym_entry_t  : one queued bus write {addr[1:0], data[7:0]}
//   YM_*        : default FIFO depth and bus timing, in clk28 cycles
//   ym_max      : integer max, used to size the shared timing counter
package ym_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } ym_state_t;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } ym_entry_t;

    localparam int YM_FIFO_DEPTH  = 4;
    localparam int YM_T_SETUP     = 1;
    localparam int YM_T_WR        = 3;
    localparam int YM_T_HOLD      = 1;
    localparam int YM_T_REC_ADDR  = 16;
    localparam int YM_T_REC_DATA  = 64;

    function automatic int ym_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ym_wr_fifo.sv
// ym_wr_fifo
// Small synchronous FIFO holding CPU writes until the bus sequencer takes them.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : enqueue din; ignored while full
//   pop        : dequeue the head; ignored while empty
//   dout       : current head entry
//   full/empty : registered status flags
//   empty_nxt  : empty flag as it will be after this edge, so the parent can
//                register status outputs without a cycle of lag
module ym_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;
    logic             full_nxt;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= empty_nxt;
            full   <= full_nxt;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ym_write_scheduler.sv
// ym_write_scheduler
// Queues Z80 port writes and replays them onto the YMF262 parallel bus with
// setup, strobe, hold and recovery timing (recovery longer after data writes).
// Ports:
//   clk28, rst         : 28 MHz clock, synchronous active-high reset
//   wr_req/addr/data   : write request, accepted while wr_ready=1
//   wr_ready           : FIFO not full
//   busy               : FIFO non-empty or bus sequence in progress
//   overflow           : sticky, a request arrived while wr_ready=0
//   ym_cs_n, ym_wr_n   : chip select / write strobe, active-low
//   ym_a, ym_d, ym_d_oe: address, data and data output enable
// Build option YM_READBACK_EN adds a status read path:
//   rd_req, rd_ready, rd_data, rd_valid, ym_rd_n, ym_d_in
// Without it those ports are absent and the enclosing top ties the YMF262
// read strobe high.
module ym_write_scheduler
    import ym_pkg::*;
#(
    parameter int FIFO_DEPTH = YM_FIFO_DEPTH,
    parameter int T_SETUP    = YM_T_SETUP,
    parameter int T_WR       = YM_T_WR,
    parameter int T_HOLD     = YM_T_HOLD,
    parameter int T_REC_ADDR = YM_T_REC_ADDR,
    parameter int T_REC_DATA = YM_T_REC_DATA
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       overflow,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    output logic [1:0] ym_a,
    output logic [7:0] ym_d,
    output logic       ym_d_oe
`ifdef YM_READBACK_EN
    ,
    input  logic       rd_req,
    output logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       ym_rd_n,
    input  logic [7:0] ym_d_in
`endif
);

    localparam int T_MAX = ym_max(ym_max(ym_max(T_SETUP, T_WR),
                                         ym_max(T_HOLD, T_REC_ADDR)),
                                  T_REC_DATA);
    localparam int CW = $clog2(T_MAX) + 1;

    // Counter reload values: a state lasts (reload + 1) cycles.
    localparam logic [CW-1:0] LD_SETUP    = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_WR       = CW'(T_WR - 1);
    localparam logic [CW-1:0] LD_HOLD     = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_REC_ADDR = CW'(T_REC_ADDR - 1);
    localparam logic [CW-1:0] LD_REC_DATA = CW'(T_REC_DATA - 1);

    ym_state_t     state;
    logic [CW-1:0] cnt;
    ym_entry_t     wr_entry;
    ym_entry_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_empty_nxt;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fsm_idle_nxt;
`ifdef YM_READBACK_EN
    logic          rd_start;
    logic          is_read;
`endif

    assign wr_entry.addr = wr_addr;
    assign wr_entry.data = wr_data;

    ym_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ym_entry_t))
    ) u_fifo (
        .clk       (clk28),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (wr_entry),
        .dout      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt)
    );

    // Acceptance looks only at the registered full flag, so a push that
    // coincides with a pop from a full FIFO is still refused.
    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_req && !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

`ifdef YM_READBACK_EN
    // A read only starts on an empty, idle scheduler; a write in the same
    // cycle takes priority and the read waits for the bus to drain.
    assign rd_start = rd_req && rd_ready && !fifo_push &&
                      (state == IDLE) && fifo_empty;
`endif

    // Predicts whether the FSM will sit in IDLE after this edge, so busy
    // and rd_ready can be registered without lagging the state.
    always_comb begin
        fsm_idle_nxt = 1'b0;
        case (state)
            IDLE: begin
                fsm_idle_nxt = !fifo_pop;
`ifdef YM_READBACK_EN
                if (rd_start) fsm_idle_nxt = 1'b0;
`endif
            end
            RECOVER: fsm_idle_nxt = (cnt == '0);
            default: fsm_idle_nxt = 1'b0;
        endcase
    end

    // Bus sequencer: one shared down-counter reloaded on every state entry;
    // all pin outputs change on the transition edges.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ym_cs_n  <= 1'b1;
            ym_wr_n  <= 1'b1;
            ym_a     <= 2'b00;
            ym_d     <= 8'h00;
            ym_d_oe  <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
`ifdef YM_READBACK_EN
            is_read  <= 1'b0;
            rd_ready <= 1'b1;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            ym_rd_n  <= 1'b1;
`endif
        end else begin
            if (wr_req && fifo_full) overflow <= 1'b1;
            busy <= !fifo_empty_nxt || !fsm_idle_nxt;
`ifdef YM_READBACK_EN
            rd_ready <= fifo_empty_nxt && fsm_idle_nxt;
            rd_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        state   <= SETUP;
                        cnt     <= LD_SETUP;
                        ym_cs_n <= 1'b0;
                        ym_d_oe <= 1'b1;
                        ym_a    <= head.addr;
                        ym_d    <= head.data;
`ifdef YM_READBACK_EN
                        is_read <= 1'b0;
                    end else if (rd_start) begin
                        state   <= SETUP;
                        cnt     <= LD_SETUP;
                        ym_cs_n <= 1'b0;
                        ym_d_oe <= 1'b0;
                        ym_a    <= 2'b00;
                        is_read <= 1'b1;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= LD_WR;
`ifdef YM_READBACK_EN
                        if (is_read) ym_rd_n <= 1'b0;
                        else         ym_wr_n <= 1'b0;
`else
                        ym_wr_n <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= LD_HOLD;
                        ym_wr_n <= 1'b1;
`ifdef YM_READBACK_EN
                        ym_rd_n <= 1'b1;
                        if (is_read) begin
                            rd_data  <= ym_d_in;
                            rd_valid <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state   <= RECOVER;
                        cnt     <= ym_a[0] ? LD_REC_DATA : LD_REC_ADDR;
                        ym_cs_n <= 1'b1;
                        ym_d_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ym_write_scheduler.sv
// tb_ym_write_scheduler
// Directed bench for ym_write_scheduler: reset state, single write timing,
// address/data recovery spacing, FIFO burst with overflow, reset during a
// strobe, and (with YM_READBACK_EN) a status read.
module tb_ym_write_scheduler;

    logic       clk28 = 1'b0;
    logic       rst;
    logic       wr_req;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       overflow;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic [1:0] ym_a;
    logic [7:0] ym_d;
    logic       ym_d_oe;
`ifdef YM_READBACK_EN
    logic       rd_req;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ym_rd_n;
    logic [7:0] ym_d_in;
    int         rd_low_cnt = 0;
    int         rd_valid_cnt = 0;
    logic [7:0] rd_data_seen = 8'h00;
`endif

    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         cs_fall_q[$];
    logic [9:0] strobe_q[$];
    logic       prev_cs_n = 1'b1;
    logic       prev_wr_n = 1'b1;

    ym_write_scheduler dut (
        .clk28    (clk28),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .overflow (overflow),
        .ym_cs_n  (ym_cs_n),
        .ym_wr_n  (ym_wr_n),
        .ym_a     (ym_a),
        .ym_d     (ym_d),
        .ym_d_oe  (ym_d_oe)
`ifdef YM_READBACK_EN
        ,
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ym_rd_n  (ym_rd_n),
        .ym_d_in  (ym_d_in)
`endif
    );

    // 28 MHz-ish clock; exact period is irrelevant to cycle-based checks.
    always #5 clk28 = ~clk28;

    // Free-running edge counter used to timestamp bus events.
    always @(posedge clk28) cycle <= cycle + 1;

    // Bus monitor on the falling edge: logs chip-select falls and the
    // address/data present at each write strobe.
    always @(negedge clk28) begin
        if (prev_cs_n && !ym_cs_n) cs_fall_q.push_back(cycle);
        if (prev_wr_n && !ym_wr_n) strobe_q.push_back({ym_a, ym_d});
        prev_cs_n = ym_cs_n;
        prev_wr_n = ym_wr_n;
`ifdef YM_READBACK_EN
        if (!ym_rd_n) rd_low_cnt++;
        if (rd_valid) begin
            rd_valid_cnt++;
            rd_data_seen = rd_data;
        end
`endif
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [1:0] addr,
                                 input logic [7:0] data);
        wr_req  = req;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Bounded wait for the scheduler to drain; a timeout shows as a failed check.
    task automatic waitBusyLow(input int budget, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 8'h00);
`ifdef YM_READBACK_EN
        rd_req  = 1'b0;
        ym_d_in = 8'h80;
`endif
        tick(); tick(); tick();

        $display("[TB] reset state");
        checkOutput("rst_cs_n",     {31'd0, ym_cs_n},  32'd1);
        checkOutput("rst_wr_n",     {31'd0, ym_wr_n},  32'd1);
        checkOutput("rst_a",        {30'd0, ym_a},     32'd0);
        checkOutput("rst_d",        {24'd0, ym_d},     32'd0);
        checkOutput("rst_d_oe",     {31'd0, ym_d_oe},  32'd0);
        checkOutput("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        checkOutput("rst_busy",     {31'd0, busy},     32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single address write");
        applyStimulus(1'b1, 2'b00, 8'h05);
        tick();                                     // edge 10: accepted
        applyStimulus(1'b0, 2'b00, 8'h00);
        checkOutput("t1_cs_n_e10", {31'd0, ym_cs_n}, 32'd1);
        checkOutput("t1_busy_e10", {31'd0, busy},    32'd1);
        tick();                                     // edge 11
        checkOutput("t1_cs_n_e11", {31'd0, ym_cs_n}, 32'd0);
        checkOutput("t1_oe_e11",   {31'd0, ym_d_oe}, 32'd1);
        checkOutput("t1_a_e11",    {30'd0, ym_a},    32'd0);
        checkOutput("t1_d_e11",    {24'd0, ym_d},    32'h05);
        checkOutput("t1_wr_n_e11", {31'd0, ym_wr_n}, 32'd1);
        for (int i = 12; i <= 14; i++) begin
            tick();
            checkOutput($sformatf("t1_wr_n_e%0d", i), {31'd0, ym_wr_n}, 32'd0);
            checkOutput($sformatf("t1_d_e%0d", i), {24'd0, ym_d}, 32'h05);
        end
        tick();                                     // edge 15
        checkOutput("t1_wr_n_e15", {31'd0, ym_wr_n}, 32'd1);
        checkOutput("t1_cs_n_e15", {31'd0, ym_cs_n}, 32'd0);
        tick();                                     // edge 16
        checkOutput("t1_cs_n_e16", {31'd0, ym_cs_n}, 32'd1);
        checkOutput("t1_oe_e16",   {31'd0, ym_d_oe}, 32'd0);
        checkOutput("t1_d_e16",    {24'd0, ym_d},    32'h05);
        for (int i = 17; i <= 31; i++) tick();
        checkOutput("t1_busy_e31", {31'd0, busy}, 32'd1);
        tick();                                     // edge 32
        checkOutput("t1_busy_e32", {31'd0, busy}, 32'd0);

        $display("[TB] address, data, address spacing");
        cs_fall_q.delete();
        strobe_q.delete();
        applyStimulus(1'b1, 2'b00, 8'h01); tick();
        applyStimulus(1'b1, 2'b01, 8'h20); tick();
        applyStimulus(1'b1, 2'b00, 8'h33); tick();
        applyStimulus(1'b0, 2'b00, 8'h00);
        waitBusyLow(300, "t2_drain");
        checkOutput("t2_cs_falls", cs_fall_q.size(), 32'd3);
        if (cs_fall_q.size() == 3) begin
            checkOutput("t2_gap_addr", cs_fall_q[1] - cs_fall_q[0], 32'd22);
            checkOutput("t2_gap_data", cs_fall_q[2] - cs_fall_q[1], 32'd70);
        end
        checkOutput("t2_strobes", strobe_q.size(), 32'd3);

        $display("[TB] burst of six writes");
        strobe_q.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'(i), 8'hA0 + 8'(i));
            tick();
            checkOutput($sformatf("t3_ready_%0d", i), {31'd0, wr_ready}, (i < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_ovf_%0d", i), {31'd0, overflow}, (i == 5) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 2'b00, 8'h00);
        waitBusyLow(600, "t3_drain");
        checkOutput("t3_strobes", strobe_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < strobe_q.size())
                checkOutput($sformatf("t3_entry_%0d", i), {22'd0, strobe_q[i]},
                            {22'd0, 2'(i), 8'hA0 + 8'(i)});
        end
        checkOutput("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        $display("[TB] reset during strobe");
        applyStimulus(1'b1, 2'b00, 8'h11); tick();   // edge N
        applyStimulus(1'b1, 2'b10, 8'h22); tick();   // N+1: cs_n low
        applyStimulus(1'b0, 2'b00, 8'h00); tick();   // N+2: first strobe cycle
        tick();                                      // N+3: second strobe cycle
        checkOutput("t4_wr_n_mid", {31'd0, ym_wr_n}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t4_wr_n",     {31'd0, ym_wr_n},  32'd1);
        checkOutput("t4_cs_n",     {31'd0, ym_cs_n},  32'd1);
        checkOutput("t4_d_oe",     {31'd0, ym_d_oe},  32'd0);
        checkOutput("t4_wr_ready", {31'd0, wr_ready}, 32'd1);
        checkOutput("t4_busy",     {31'd0, busy},     32'd0);
        checkOutput("t4_overflow", {31'd0, overflow}, 32'd0);
        s0 = strobe_q.size();
        for (int i = 0; i < 120; i++) tick();
        checkOutput("t4_no_strobe", strobe_q.size(), s0);
        checkOutput("t4_cs_idle",   {31'd0, ym_cs_n}, 32'd1);

`ifdef YM_READBACK_EN
        $display("[TB] status read");
        applyStimulus(1'b1, 2'b00, 8'h44);
        rd_req = 1'b1;                               // same cycle: write wins
        tick();
        applyStimulus(1'b0, 2'b00, 8'h00);
        checkOutput("t5_rd_ready_held", {31'd0, rd_ready}, 32'd0);
        begin
            int n = 0;
            while (busy !== 1'b0 && n < 200) begin
                tick();
                n++;
            end
        end
        checkOutput("t5_busy_drop",   {31'd0, busy},     32'd0);
        checkOutput("t5_rd_ready",    {31'd0, rd_ready}, 32'd1);
        checkOutput("t5_no_early_rd", rd_valid_cnt,      32'd0);
        tick();                                      // read accepted
        rd_req = 1'b0;
        checkOutput("t5_cs_n", {31'd0, ym_cs_n}, 32'd0);
        checkOutput("t5_a",    {30'd0, ym_a},    32'd0);
        checkOutput("t5_oe",   {31'd0, ym_d_oe}, 32'd0);
        waitBusyLow(100, "t5_drain");
        checkOutput("t5_rd_n_len",   rd_low_cnt,   32'd3);
        checkOutput("t5_valid_cnt",  rd_valid_cnt, 32'd1);
        checkOutput("t5_rd_data",    {24'd0, rd_data_seen}, 32'h80);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ym_write_scheduler.md
Name: ym_write_scheduler

Overview:
- Sequences CPU port writes to the YMF262 parallel bus (ym_a, chip select, write strobe, data) in the clk28 domain.
- Buffers bursts of Z80 OUTs in a small FIFO so the CPU is never stalled.
- Enforces write-pulse, setup, hold and post-write recovery timing, with separate recovery times after address writes and data writes.
- Sits between the port decoder and the YMF262 pins in the karabas_opl3 top.

Parameters:
- FIFO_DEPTH, 4, entries; power of two, at least 2.
- T_SETUP, 1, clk28 cycles with cs_n low and address/data valid before wr_n falls; at least 1.
- T_WR, 3, clk28 cycles wr_n is held low; at least 1.
- T_HOLD, 1, clk28 cycles cs_n stays low and data stays driven after wr_n rises; at least 1.
- T_REC_ADDR, 16, idle clk28 cycles after a write with ym_a[0]=0 (address write); at least 1.
- T_REC_DATA, 64, idle clk28 cycles after a write with ym_a[0]=1 (data write); at least 1.

Ports:
- clk28  in  1  28 MHz system clock.
- rst  in  1  synchronous reset, active-high.
- wr_req  in  1  write request; accepted on a clk28 edge when wr_ready=1.
- wr_addr  in  2  {bank A1, A0} for this write.
- wr_data  in  8  byte to write.
- wr_ready  out  1  FIFO not full.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky: a wr_req arrived while wr_ready=0.
- ym_cs_n  out  1  YMF262 chip select, active-low.
- ym_wr_n  out  1  YMF262 write strobe, active-low.
- ym_a  out  2  YMF262 A1:A0.
- ym_d  out  8  YMF262 data bus output.
- ym_d_oe  out  1  data bus output enable.

Interface decision: one clock, clk28; reset rst is synchronous and active-high.

Behaviour:
- Reset values: ym_cs_n=1, ym_wr_n=1, ym_a=0, ym_d=0, ym_d_oe=0, wr_ready=1, busy=0, overflow=0.
- Reset effects: FIFO emptied, FSM forced to IDLE, counters cleared.
- All outputs are registered.
- FIFO:
  - Push when wr_req && wr_ready.
  - wr_ready is computed from the current full flag only. A push arriving in the same cycle as a pop from a full FIFO is rejected and sets overflow.
  - A rejected write is dropped; overflow stays set until rst.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter is reloaded on each state entry.
- IDLE:
  - If the FIFO is non-empty, pop the head into a holding register and go to SETUP.
  - ym_cs_n=0, ym_d_oe=1, ym_a and ym_d take the popped entry, all at the same edge.
- SETUP: after T_SETUP cycles, go to STROBE and drive ym_wr_n=0.
- STROBE: after T_WR cycles, go to HOLD and drive ym_wr_n=1. Address and data stay stable.
- HOLD: after T_HOLD cycles, go to RECOVER and drive ym_cs_n=1, ym_d_oe=0. ym_a and ym_d keep their last values.
- RECOVER:
  - Count T_REC_ADDR if the held ym_a[0]=0, else T_REC_DATA, then go to IDLE.
  - The FIFO head is not examined until IDLE.
- Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE gives ym_cs_n low after edge N+1.
- Minimum write-to-write spacing: T_SETUP+T_WR+T_HOLD+T_REC+1 cycles.
- Reset mid-operation: at the rst edge ym_wr_n and ym_cs_n go high and ym_d_oe goes low in the same cycle. The in-flight and queued writes are lost.
- Counter width: $clog2 of the largest timing parameter plus 1.
- FIFO pointers: wrap modulo FIFO_DEPTH, with an extra bit for full/empty detection.

Optional Feature:
YM_READBACK_EN
- When defined, adds these ports:
  - rd_req  in  1
  - rd_ready  out  1
  - rd_data  out  8
  - rd_valid  out  1
  - ym_rd_n  out  1
  - ym_d_in  in  8
- A read is accepted only when the FIFO is empty and the FSM is in IDLE; rd_ready reflects this.
- Read sequence: cs_n low with ym_a=00 (status), then SETUP, then ym_rd_n low for T_WR cycles.
- ym_d_in is sampled on the last STROBE cycle. rd_valid pulses for one cycle with rd_data in the next cycle.
- The read then passes through HOLD and RECOVER with T_REC_ADDR.
- If wr_req and rd_req arrive in the same cycle, the write wins and the read waits.
- Without the macro: none of these ports exist, and ym_rd_n is tied high at the top level.

Decomposition:
- Package ym_pkg holds:
  - FSM state enum (IDLE, SETUP, STROBE, HOLD, RECOVER).
  - Write-entry struct {addr[1:0], data[7:0]}.
  - Default timing constants.
- One sub-module: ym_wr_fifo, a parameterised synchronous FIFO with push, pop, full, empty and head data.

Test Plan:
- Single write: wr_addr=00, wr_data=0x05 at edge 10.
  - cs_n low from edge 11; wr_n low during edges 12-14; cs_n high at edge 16; busy clear after 16 RECOVER cycles.
  - ym_a=00 and ym_d=0x05 stable throughout.
- Address then data writes: wr_addr=00/0x01, then wr_addr=01/0x20.
  - Second cs_n fall exactly 1+3+1+16+1=22 cycles after the first.
  - A following write waits 64 recovery cycles after the data write.
- Burst of 6 writes on consecutive cycles, FIFO_DEPTH=4, FSM idle.
  - wr_ready falls after the 5th accepted push (one entry already popped); the 6th sets overflow.
  - Exactly 5 strobes appear on the YM bus, in order.
- rst asserted during the 2nd STROBE cycle.
  - Next edge: wr_n=1, cs_n=1, d_oe=0, FIFO empty, overflow=0.
  - No further strobes until a new write is issued.
- Status read with YM_READBACK_EN: ym_d_in=0x80 with the bus idle.
  - ym_rd_n low for 3 cycles; rd_valid is a single pulse with rd_data=0x80.
  - rd_req issued while a write is queued is held off until busy drops.
